// File: rtl/am_pkg.sv
// am_pkg: shared sample width, ramp FSM encoding and envelope clamp limits.
package am_pkg;
  localparam int W = 8;
  localparam int ENV_MIN = 0;
  localparam int ENV_MAX = 255;
  typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, RAMP_DOWN = 2'd3} am_state_t;
endpackage

// File: rtl/am_modulator_if.sv
// am_modulator_if: control inputs, audio/carrier sample streams and modulated output of the AM modulator.
interface am_modulator_if;
  import am_pkg::*;
  logic enable;
  logic [W-1:0] dc_level;
  logic [W-1:0] mod_index;
  logic signed [W-1:0] audio;
  logic audio_valid;
  logic signed [W-1:0] carrier;
  logic carrier_valid;
  logic signed [W-1:0] am_out;
  logic out_valid;
  logic clip;
  logic running;
  modport master (
    output enable, dc_level, mod_index, audio, audio_valid, carrier, carrier_valid,
    input am_out, out_valid, clip, running
  );
  modport slave (
    input enable, dc_level, mod_index, audio, audio_valid, carrier, carrier_valid,
    output am_out, out_valid, clip, running
  );
endinterface

// File: rtl/am_ramp_ctrl.sv
// am_ramp_ctrl: soft-start/stop FSM stepping the carrier level by one every RAMP_DIV carrier samples.
module am_ramp_ctrl
  import am_pkg::*;
#(
  parameter int RAMP_DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         carrier_valid,
  input  logic [W-1:0] dc_level,
  output logic [W-1:0] ramp_lvl,
  output logic         running,
  output logic         audio_gate
);
  localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(RAMP_DIV - 1);
  am_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] lvl_nxt;
  logic tick;
  assign tick = carrier_valid && cnt == CMAX;
  assign running = state == RUN;
  assign audio_gate = state == RUN;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ramp_lvl <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      ramp_lvl <= lvl_nxt;
      if (carrier_valid) cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
  // enable is tested before the level compare so a drop always wins
  always_comb begin
    state_nxt = state;
    lvl_nxt = ramp_lvl;
    case (state)
      IDLE: begin
        lvl_nxt = '0;
        state_nxt = enable ? RAMP_UP : IDLE;
      end
      RAMP_UP: begin
        lvl_nxt = tick && ramp_lvl < dc_level ? ramp_lvl + 1'b1 : ramp_lvl;
        state_nxt = !enable ? RAMP_DOWN : ramp_lvl >= dc_level ? RUN : RAMP_UP;
      end
      RUN: begin
        lvl_nxt = !tick || ramp_lvl == dc_level ? ramp_lvl
                : ramp_lvl < dc_level ? ramp_lvl + 1'b1 : ramp_lvl - 1'b1;
        state_nxt = enable ? RUN : RAMP_DOWN;
      end
      RAMP_DOWN: begin
        lvl_nxt = tick && ramp_lvl != '0 ? ramp_lvl - 1'b1 : ramp_lvl;
        state_nxt = enable ? RAMP_UP : ramp_lvl == '0 ? IDLE : RAMP_DOWN;
      end
    endcase
  end
endmodule

// File: rtl/am_modulator.sv
// am_modulator: carrier x clamp(ramped DC level + gated audio x depth), three-stage pipeline.
module am_modulator
  import am_pkg::*;
#(
  parameter int RAMP_DIV = 16
) (
  input logic clk,
  input logic rst,
  am_modulator_if.slave bus
);
  localparam int PW = 2 * W + 1;
  localparam logic signed [W+1:0] LO = (W + 2)'(ENV_MIN);
  localparam logic signed [W+1:0] HI = (W + 2)'(ENV_MAX);
  logic [W-1:0] ramp_lvl, lvl1, env, env2;
  logic gate, v1, v2, clip2, clamp_lo, clamp_hi, unused;
  logic signed [W-1:0] audio_hold, car1, car2;
  logic signed [PW-1:0] prod_a, prod_o;
  logic signed [W+1:0] p, p1, sum;
  am_ramp_ctrl #(.RAMP_DIV(RAMP_DIV)) u_ramp (
    .clk(clk),
    .rst(rst),
    .enable(bus.enable),
    .carrier_valid(bus.carrier_valid),
    .dc_level(bus.dc_level),
    .ramp_lvl(ramp_lvl),
    .running(bus.running),
    .audio_gate(gate)
  );
  // the high slice of each product is the floor of product / 256
  assign prod_a = PW'(audio_hold) * PW'($signed({1'b0, bus.mod_index}));
  assign p = gate ? {prod_a[PW-1], prod_a[PW-1:W]} : '0;
  assign sum = $signed({2'b00, lvl1}) + p1;
  assign clamp_lo = sum < LO;
  assign clamp_hi = sum > HI;
  assign env = clamp_lo ? W'(ENV_MIN) : clamp_hi ? W'(ENV_MAX) : sum[W-1:0];
  assign prod_o = PW'($signed({1'b0, env2})) * PW'(car2);
  assign unused = ^{prod_a[W-1:0], prod_o[PW-1], prod_o[W-1:0]};
  always_ff @(posedge clk) begin
    if (!rst) begin
      audio_hold <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
      lvl1 <= '0;
      car1 <= '0;
      car2 <= '0;
      env2 <= '0;
      clip2 <= 1'b0;
      bus.am_out <= '0;
      bus.out_valid <= 1'b0;
      bus.clip <= 1'b0;
    end else begin
      if (bus.audio_valid) audio_hold <= bus.audio;
      v1 <= bus.carrier_valid;
      p1 <= p;
      lvl1 <= ramp_lvl;
      car1 <= bus.carrier;
      v2 <= v1;
      env2 <= env;
      clip2 <= clamp_lo || clamp_hi;
      car2 <= car1;
      bus.out_valid <= v2;
      if (v2) begin
        bus.am_out <= prod_o[2*W-1:W];
        bus.clip <= clip2;
      end
    end
  end
endmodule

// File: tb/tb_am_modulator.sv
// tb_am_modulator: randomized and directed checks of am_modulator against a cycle-level behavioural model.
module tb_am_modulator;
  import am_pkg::*;
  localparam int RAMP_DIV = 4;
  typedef enum {M_OFF, M_UP, M_ON, M_DOWN} mode_t;
  typedef struct {
    int am;
    bit clip;
    int rem;
  } samp_t;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  samp_t pipe[$];
  mode_t m_mode;
  int m_lvl, m_cnt, m_hold, m_out;
  bit m_clip, m_ov, m_run;
  am_modulator_if bus ();
  am_modulator #(.RAMP_DIV(RAMP_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // applies the current inputs to the model, then advances one clock
  task automatic step();
    int p, e, nl, dc;
    bit tk;
    mode_t nm;
    samp_t s;
    if (!rst) begin
      m_mode = M_OFF;
      m_lvl = 0;
      m_cnt = 0;
      m_hold = 0;
      m_out = 0;
      m_clip = 0;
      m_ov = 0;
      pipe.delete();
    end else begin
      dc = int'(bus.dc_level);
      if (bus.carrier_valid) begin
        p = m_mode == M_ON ? (m_hold * int'(bus.mod_index)) >>> 8 : 0;
        e = m_lvl + p;
        s.clip = e < 0 || e > 255;
        e = e < 0 ? 0 : e > 255 ? 255 : e;
        s.am = (e * int'(bus.carrier)) >>> 8;
        s.rem = 3;
        pipe.push_back(s);
      end
      foreach (pipe[i]) pipe[i].rem--;
      m_ov = 0;
      if (pipe.size() > 0 && pipe[0].rem == 0) begin
        s = pipe.pop_front();
        m_ov = 1;
        m_out = s.am;
        m_clip = s.clip;
      end
      tk = bus.carrier_valid && m_cnt == RAMP_DIV - 1;
      if (bus.carrier_valid) m_cnt = (m_cnt + 1) % RAMP_DIV;
      nl = m_lvl;
      nm = m_mode;
      case (m_mode)
        M_OFF: begin
          nl = 0;
          if (bus.enable) nm = M_UP;
        end
        M_UP: begin
          if (tk && m_lvl < dc) nl++;
          nm = !bus.enable ? M_DOWN : m_lvl >= dc ? M_ON : M_UP;
        end
        M_ON: begin
          if (tk && m_lvl != dc) nl += dc > m_lvl ? 1 : -1;
          if (!bus.enable) nm = M_DOWN;
        end
        M_DOWN: begin
          if (tk && m_lvl > 0) nl--;
          nm = bus.enable ? M_UP : m_lvl == 0 ? M_OFF : M_DOWN;
        end
      endcase
      m_lvl = nl;
      m_mode = nm;
      if (bus.audio_valid) m_hold = int'(bus.audio);
    end
    m_run = m_mode == M_ON;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.dc_level = 8'd50;
    bus.mod_index = 8'd0;
    bus.audio = '0;
    bus.audio_valid = 1'b0;
    bus.carrier = '0;
    for (int i = 0; i < 6; i++) begin
      bus.enable = 1'b1;
      bus.carrier_valid = 1'b1;
      bus.carrier = W'($urandom);
      bus.audio_valid = 1'($urandom);
      bus.audio = W'($urandom);
      step();
      if (bus.out_valid !== 1'b0 || bus.am_out !== 8'sd0 || bus.running !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got v=%b out=%0d run=%b, want v=0 out=0 run=0", bus.out_valid, bus.am_out, bus.running);
      end
      checks++;
    end
    rst = 1'b1;
    bus.enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.carrier_valid = 1'($urandom);
      bus.carrier = W'($urandom);
      bus.audio_valid = 1'($urandom);
      bus.audio = W'($urandom);
      bus.mod_index = W'($urandom);
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== 8'sd0 || bus.running !== 1'b0) begin
        errors++;
        $display("FAIL idle_silent: got v=%b out=%0d run=%b, want v=%b out=0 run=0", bus.out_valid, bus.am_out, bus.running, m_ov);
      end
      checks++;
    end
  endtask
  task automatic test_ramp();
    rst = 1'b0;
    bus.carrier_valid = 1'b0;
    step();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.dc_level = 8'd3;
    bus.mod_index = 8'd0;
    bus.audio_valid = 1'b0;
    bus.carrier = 8'sd127;
    bus.carrier_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL ramp_model step %0d: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", i, bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
      if ((i == 12 && bus.running !== 1'b0) || (i == 13 && bus.running !== 1'b1)) begin
        errors++;
        $display("FAIL ramp_running step %0d: got run=%b, want run=%b", i, bus.running, i == 13);
      end
      if (i == 12 || i == 13) checks++;
    end
    if (bus.am_out !== 8'sd1) begin
      errors++;
      $display("FAIL ramp_lvl3_out: got %0d, want 1", bus.am_out);
    end
    checks++;
  endtask
  task automatic test_modulation();
    int aud[2] = '{100, -128};
    int car[2] = '{127, -128};
    int exp_out[2] = '{88, -32};
    bus.dc_level = 8'd128;
    bus.mod_index = 8'd128;
    bus.carrier_valid = 1'b1;
    for (int i = 0; i < 600 && m_lvl != 128; i++) begin
      bus.carrier = W'($urandom);
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL mod_climb: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
    checks++;
    if (m_lvl != 128) begin
      errors++;
      $display("FAIL mod_climb_timeout: level %0d, want 128", m_lvl);
    end
    for (int k = 0; k < 2; k++) begin
      bus.carrier_valid = 1'b0;
      bus.audio = W'(aud[k]);
      bus.audio_valid = 1'b1;
      step();
      bus.audio_valid = 1'b0;
      repeat (3) step();
      bus.carrier = W'(car[k]);
      bus.carrier_valid = 1'b1;
      step();
      bus.carrier_valid = 1'b0;
      step();
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mod_early_%0d: got v=%b, want v=0", k, bus.out_valid);
      end
      checks++;
      step();
      if (bus.out_valid !== 1'b1 || bus.am_out !== W'(exp_out[k]) || bus.clip !== 1'b0) begin
        errors++;
        $display("FAIL mod_out_%0d: got v=%b out=%0d clip=%b, want v=1 out=%0d clip=0", k, bus.out_valid, bus.am_out, bus.clip, exp_out[k]);
      end
      checks++;
    end
    for (int i = 0; i < 40; i++) begin
      bus.audio_valid = 1'($urandom);
      bus.audio = W'($urandom);
      bus.carrier_valid = 1'($urandom);
      bus.carrier = W'($urandom);
      bus.mod_index = W'($urandom);
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL mod_rand %0d: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", i, bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
  endtask
  task automatic test_clip();
    bus.dc_level = 8'd200;
    bus.mod_index = 8'd255;
    bus.audio_valid = 1'b0;
    bus.carrier_valid = 1'b1;
    for (int i = 0; i < 400 && m_lvl != 200; i++) begin
      bus.carrier = W'($urandom);
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL clip_climb: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
    bus.carrier_valid = 1'b0;
    bus.audio = 8'sd127;
    bus.audio_valid = 1'b1;
    step();
    bus.audio_valid = 1'b0;
    repeat (3) step();
    bus.carrier = 8'sd100;
    bus.carrier_valid = 1'b1;
    step();
    bus.carrier_valid = 1'b0;
    step();
    step();
    if (bus.out_valid !== 1'b1 || bus.am_out !== 8'sd99 || bus.clip !== 1'b1) begin
      errors++;
      $display("FAIL clip_high: got v=%b out=%0d clip=%b, want v=1 out=99 clip=1", bus.out_valid, bus.am_out, bus.clip);
    end
    checks++;
  endtask
  task automatic test_ramp_down();
    bus.enable = 1'b1;
    bus.dc_level = 8'd128;
    bus.mod_index = 8'd255;
    bus.carrier_valid = 1'b1;
    for (int i = 0; i < 400 && m_lvl != 128; i++) begin
      bus.audio_valid = 1'($urandom);
      bus.audio = W'($urandom);
      bus.carrier = W'($urandom);
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL down_settle: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
    bus.enable = 1'b0;
    bus.audio = 8'sd127;
    bus.audio_valid = 1'b1;
    bus.carrier = 8'sd127;
    step();
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL down_running: got run=%b, want run=0", bus.running);
    end
    checks++;
    bus.audio_valid = 1'b0;
    for (int i = 0; i < 400 && m_lvl > 64; i++) begin
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL down_ramp: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
    checks++;
    if (m_lvl != 64) begin
      errors++;
      $display("FAIL down_timeout: level %0d, want 64", m_lvl);
    end
    bus.enable = 1'b1;
    bus.mod_index = 8'd0;
    repeat (3) step();
    if (bus.am_out !== 8'sd31) begin
      errors++;
      $display("FAIL resume_from_64: got %0d, want 31", bus.am_out);
    end
    checks++;
    for (int i = 0; i < 400 && !m_run; i++) begin
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL resume_ramp: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
    repeat (3) step();
    if (bus.running !== 1'b1 || bus.am_out !== 8'sd63) begin
      errors++;
      $display("FAIL resume_run_128: got run=%b out=%0d, want run=1 out=63", bus.running, bus.am_out);
    end
    checks++;
  endtask
  task automatic test_audio_hold();
    bus.mod_index = 8'd128;
    bus.carrier_valid = 1'b0;
    bus.audio = 8'sd0;
    bus.audio_valid = 1'b1;
    step();
    bus.audio_valid = 1'b0;
    repeat (3) step();
    bus.audio = 8'sd100;
    bus.audio_valid = 1'b1;
    bus.carrier = 8'sd127;
    bus.carrier_valid = 1'b1;
    step();
    bus.audio_valid = 1'b0;
    step();
    bus.carrier_valid = 1'b0;
    step();
    if (bus.out_valid !== 1'b1 || bus.am_out !== 8'sd63) begin
      errors++;
      $display("FAIL hold_old_audio: got v=%b out=%0d, want v=1 out=63", bus.out_valid, bus.am_out);
    end
    checks++;
    step();
    if (bus.out_valid !== 1'b1 || bus.am_out !== 8'sd88) begin
      errors++;
      $display("FAIL hold_new_audio: got v=%b out=%0d, want v=1 out=88", bus.out_valid, bus.am_out);
    end
    checks++;
    step();
  endtask
  task automatic test_back_to_back();
    bus.carrier_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.audio_valid = 1'($urandom);
      bus.audio = W'($urandom);
      bus.carrier = W'($urandom);
      bus.mod_index = W'($urandom);
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run || (i >= 2 && bus.out_valid !== 1'b1)) begin
        errors++;
        $display("FAIL b2b %0d: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", i, bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
  endtask
  task automatic test_reset_mid();
    bus.carrier_valid = 1'b1;
    repeat (5) begin
      bus.carrier = W'($urandom);
      step();
    end
    rst = 1'b0;
    step();
    if (bus.out_valid !== 1'b0 || bus.am_out !== 8'sd0 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b out=%0d run=%b, want v=0 out=0 run=0", bus.out_valid, bus.am_out, bus.running);
    end
    checks++;
    rst = 1'b1;
    bus.carrier_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale %0d: got v=%b, want v=0", i, bus.out_valid);
      end
      checks++;
    end
    for (int i = 0; i < 30; i++) begin
      bus.carrier_valid = 1'($urandom);
      bus.carrier = W'($urandom);
      bus.audio_valid = 1'($urandom);
      bus.audio = W'($urandom);
      bus.dc_level = W'($urandom_range(0, 3));
      step();
      if (bus.out_valid !== m_ov || bus.am_out !== W'(m_out) || bus.clip !== m_clip || bus.running !== m_run) begin
        errors++;
        $display("FAIL mid_after %0d: got v=%b out=%0d clip=%b run=%b, want v=%b out=%0d clip=%b run=%b", i, bus.out_valid, bus.am_out, bus.clip, bus.running, m_ov, m_out, m_clip, m_run);
      end
      checks++;
    end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_modulation();
    test_clip();
    test_ramp_down();
    test_audio_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/am_modulator.md
Name: am_modulator

Overview:
- Transmit-side counterpart of the receiver's DC-offset tracker.
- Builds an AM signal: carrier × (DC carrier level + scaled audio).
- Sits between the audio sample source and the DAC path. Takes a carrier-rate sample stream and a slower audio stream.
- A soft-start/stop ramp on the DC level avoids on/off clicks.

Parameters:
- RAMP_DIV, 16: carrier samples per ±1 step of the ramp level (≥1).
- W, 8: sample width of audio, carrier, dc_level, mod_index and am_out.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- enable  in  1  level; high = transmit, low = ramp down to silence.
- dc_level  in  W  unsigned carrier level (target envelope).
- mod_index  in  W  unsigned modulation depth, Q0.8 (255 ≈ 1.0).
- audio  in  W  signed audio sample.
- audio_valid  in  1  strobe; load audio into hold register.
- carrier  in  W  signed carrier sample.
- carrier_valid  in  1  strobe; one carrier sample per pulse.
- am_out  out  W  signed modulated sample.
- out_valid  out  1  strobe; am_out valid.
- clip  out  1  high with out_valid when the envelope was clamped.
- running  out  1  high while the state is RUN.

Behaviour:

Reset (rst low at clk edge):
- state=IDLE; ramp_lvl=0; tick counter=0; audio hold=0; pipeline cleared.
- am_out=0, out_valid=0, clip=0, running=0.
- Mid-operation reset discards in-flight samples. out_valid is low from the next edge.

Audio hold:
- audio_valid loads the hold register.
- Each value is reused for every carrier sample until replaced.
- A value loaded in cycle N affects carrier samples accepted in cycle N+1 onward.

Tick:
- Counter increments on carrier_valid. At RAMP_DIV-1 it wraps to 0 and raises a one-cycle tick.
- It is not advanced without carrier_valid.

FSM states: IDLE, RAMP_UP, RUN, RAMP_DOWN.
- IDLE: ramp_lvl=0. enable=1 → RAMP_UP.
- RAMP_UP:
  - On tick, ramp_lvl+1.
  - When ramp_lvl==dc_level → RUN, checked every cycle; dc_level=0 reaches RUN the cycle after entry.
  - If dc_level drops below ramp_lvl → RUN.
- RUN:
  - On tick, ramp_lvl steps ±1 toward dc_level, so level changes are also click-free.
  - running=1.
- RAMP_DOWN:
  - On tick, ramp_lvl-1. ramp_lvl==0 → IDLE.
  - enable=1 → RAMP_UP from the current ramp_lvl.
- From RAMP_UP or RUN, enable=0 → RAMP_DOWN next cycle. enable has priority over level compare.

Datapath (3-stage, all stages advance every cycle; valid bit travels with data):
- S1 (cycle of carrier_valid, registered at its edge):
  - p = (audio_hold × mod_index) >>> 8, using a 17-bit signed product; arithmetic shift, floor.
  - p forced to 0 unless state==RUN.
  - Register carrier and ramp_lvl.
- S2: e = ramp_lvl + p, in 10-bit signed. Clamp to [0, 255]. clip_s2 = (clamped).
- S3: am_out = (e × carrier) >>> 8, floor, 17-bit signed product. Result fits W bits; no saturation.
- Output timing: out_valid asserts exactly 3 cycles after carrier_valid. Back-to-back carrier_valid gives back-to-back out_valid.
- Between strobes, am_out and clip hold their last values. clip is meaningful only with out_valid.
- No backpressure: the downstream sink must accept every out_valid.

Decomposition:
- Shared package am_pkg:
  - W.
  - FSM state enum (2-bit: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3).
  - Envelope clamp limits ENV_MIN=0, ENV_MAX=255.
- One natural sub-module: am_ramp_ctrl. It holds the FSM, tick counter and ramp_lvl, and outputs ramp_lvl, running and the audio gate.
- The pipeline stays in am_modulator.

Test Plan:
1. Reset: hold rst=0 while driving carrier_valid → out_valid=0, am_out=0, running=0. Release; keep enable=0 → am_out=0 for all samples.
2. Ramp: RAMP_DIV=4, dc_level=3, enable=1, carrier_valid every cycle, carrier=127.
   - ramp_lvl goes 1, 2, 3 after carrier samples 4, 8, 12; running rises after sample 12.
   - am_out at ramp_lvl=3 is 1 (381>>>8).
3. Modulation in RUN: dc_level=128, mod_index=128.
   - audio=100, carrier=127 → am_out=88, clip=0, 3 cycles after carrier_valid.
   - audio=-128, carrier=-128 → am_out=-32.
4. Clip: dc_level=200, mod_index=255, audio=127, carrier=100 → envelope 326 clamped to 255; am_out=99; clip=1.
5. Ramp-down/re-enable:
   - From RUN at level 128, drop enable → running=0 next cycle; audio ignored; level falls 1 per tick.
   - Re-raise enable at level 64 → RAMP_UP resumes from 64, reaches RUN at 128.
6. Audio hold and timing:
   - audio_valid and carrier_valid in the same cycle → that sample uses the old audio; the next sample uses the new value.
   - Assert rst mid-stream → out_valid low the next cycle, no stale outputs after release.
